// File: rtl/tone_period_meter.sv
// Tone period meter: measures the period of an incoming square-wave tone in
// clockIn cycles and recovers the modulation step the tone generator applied
// (generator half-period = N + step, N = FrecIn/(2*FrecOut)).
//
// Ports:
//   clockIn     in   system clock, all logic on the rising edge
//   resetN      in   asynchronous active-low reset
//   toneIn      in   asynchronous square-wave tone
//   period      out  last measured full period in cycles
//   step        out  decoded step (period/2 - N) for the last period
//   inRange     out  step is valid for the last period
//   periodValid out  one-cycle pulse when period/step/inRange update
//   locked      out  two consecutive equal in-range periods seen
//   noSignal    out  no rising edge within MaxCount cycles
module tone_period_meter #(
    parameter int unsigned FrecIn   = 25000,
    parameter int unsigned FrecOut  = 440,
    parameter int unsigned MaxStep  = 12,
    parameter int unsigned MaxCount = 1024,
    parameter int unsigned CntW     = 16
) (
    input  logic            clockIn,
    input  logic            resetN,
    input  logic            toneIn,
    output logic [CntW-1:0] period,
    output logic [3:0]      step,
    output logic            inRange,
    output logic            periodValid,
    output logic            locked,
    output logic            noSignal
);

    localparam int unsigned N     = FrecIn / (2 * FrecOut);
    localparam int unsigned StepW = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } stateT;

    stateT           state;
    logic            syncA;
    logic            syncB;
    logic            prevTone;
    logic            rise;
    logic [CntW-1:0] counter;
    logic [CntW-1:0] lastPeriod;
    logic            lastValid;

    logic [CntW-1:0]  half;
    logic             halfGeN;
    logic [CntW-1:0]  offset;
    logic             decodeOk;
    logic [StepW-1:0] decodeStep;

    // Rising edge of the synchronized tone.
    assign rise = syncB & ~prevTone;

    // Step decode of the running count; only meaningful when a rise closes the period.
    always_comb begin
        half       = counter >> 1;
        halfGeN    = (half >= CntW'(N));
        offset     = '0;
        decodeOk   = 1'b0;
        decodeStep = '0;
        if (halfGeN) begin
            // Subtraction only when it cannot wrap.
            offset = half - CntW'(N);
        end
        if (!counter[0] && halfGeN && (offset <= CntW'(MaxStep))) begin
            decodeOk   = 1'b1;
            decodeStep = StepW'(offset);
        end
    end

    // Synchronizer, measurement FSM and registered outputs.
    always_ff @(posedge clockIn or negedge resetN) begin
        if (!resetN) begin
            syncA       <= 1'b0;
            syncB       <= 1'b0;
            prevTone    <= 1'b0;
            state       <= IDLE;
            counter     <= '0;
            lastPeriod  <= '0;
            lastValid   <= 1'b0;
            period      <= '0;
            step        <= '0;
            inRange     <= 1'b0;
            periodValid <= 1'b0;
            locked      <= 1'b0;
            noSignal    <= 1'b1;
        end else begin
            syncA       <= toneIn;
            syncB       <= syncA;
            prevTone    <= syncB;
            periodValid <= 1'b0;

            case (state)
                IDLE: begin
                    counter <= '0;
                    if (rise) begin
                        state   <= MEASURE;
                        counter <= CntW'(1);
                    end
                end

                MEASURE: begin
                    if (rise) begin
                        // A rise on the timeout cycle still counts as a measurement.
                        period      <= counter;
                        step        <= decodeStep;
                        inRange     <= decodeOk;
                        periodValid <= 1'b1;
                        noSignal    <= 1'b0;
                        locked      <= lastValid && (counter == lastPeriod) && decodeOk;
                        lastPeriod  <= counter;
                        lastValid   <= 1'b1;
                        counter     <= CntW'(1);
                    end else if (counter == CntW'(MaxCount)) begin
                        // Timeout: period/step hold, history is discarded.
                        noSignal  <= 1'b1;
                        locked    <= 1'b0;
                        inRange   <= 1'b0;
                        lastValid <= 1'b0;
                        state     <= IDLE;
                        counter   <= '0;
                    end else begin
                        counter <= counter + CntW'(1);
                    end
                end

                default: begin
                    state   <= IDLE;
                    counter <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_period_meter.sv
// Testbench for tone_period_meter: drives tone waveforms and compares every
// periodValid pulse against expectations derived from input rise times.
module tb_tone_period_meter;

    localparam int unsigned N      = 28;
    localparam int unsigned MAXSTP = 12;
    localparam int unsigned MAXCNT = 1024;
    localparam int unsigned CNTW   = 16;

    logic            clockIn = 1'b0;
    logic            resetN;
    logic            toneIn;
    logic [CNTW-1:0] period;
    logic [3:0]      step;
    logic            inRange;
    logic            periodValid;
    logic            locked;
    logic            noSignal;

    always #5 clockIn = ~clockIn;

    tone_period_meter #(
        .FrecIn  (25000),
        .FrecOut (440),
        .MaxStep (MAXSTP),
        .MaxCount(MAXCNT),
        .CntW    (CNTW)
    ) dut (
        .clockIn    (clockIn),
        .resetN     (resetN),
        .toneIn     (toneIn),
        .period     (period),
        .step       (step),
        .inRange    (inRange),
        .periodValid(periodValid),
        .locked     (locked),
        .noSignal   (noSignal)
    );

    typedef struct packed {
        logic [CNTW-1:0] p;
        logic [3:0]      s;
        logic            ir;
        logic            lk;
        logic            ns;
    } measT;

    measT expQ[$];
    measT obsQ[$];
    measT e;
    measT o;

    int nTests = 0;
    int nFail  = 0;

    // Monitor state
    int   ncyc      = 0;
    int   pvCyc     = 0;
    int   nsRiseCyc = -1;
    logic nsPrev;

    // Reference model state: works purely on input rise times
    logic mCur       = 1'b0;
    bit   mArmed     = 1'b0;
    int   mLastRise  = 0;
    int   mCyc       = 0;
    bit   mPrevValid = 1'b0;
    int   mPrevP     = 0;

    always @(negedge clockIn) begin
        ncyc++;
        if (periodValid === 1'b1) begin
            o.p  = period;
            o.s  = step;
            o.ir = inRange;
            o.lk = locked;
            o.ns = noSignal;
            obsQ.push_back(o);
            pvCyc = ncyc;
        end
        if (noSignal === 1'b1 && nsPrev === 1'b0) nsRiseCyc = ncyc;
        nsPrev = noSignal;
    end

    // Expected result of a measured period of p cycles.
    function automatic void modelMeasure(input int p);
        measT m;
        bit   ok;
        ok   = (p % 2 == 0) && (p / 2 >= int'(N)) && (p / 2 - int'(N) <= int'(MAXSTP));
        m.p  = CNTW'(p);
        m.s  = ok ? 4'(p / 2 - int'(N)) : 4'd0;
        m.ir = ok;
        m.lk = mPrevValid && (p == mPrevP) && ok;
        m.ns = 1'b0;
        mPrevP     = p;
        mPrevValid = 1'b1;
        expQ.push_back(m);
    endfunction

    function automatic void modelReset();
        mArmed     = 1'b0;
        mPrevValid = 1'b0;
        mCur       = 1'b0;
        expQ.delete();
        obsQ.delete();
    endfunction

    // Drive toneIn = v for n cycles, advancing the model each cycle.
    task automatic drv(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clockIn);
            toneIn = v;
            mCyc++;
            if (mArmed) begin
                if (v && !mCur) begin
                    modelMeasure(mCyc - mLastRise);
                    mLastRise = mCyc;
                end else if (mCyc - mLastRise == int'(MAXCNT)) begin
                    mArmed     = 1'b0;
                    mPrevValid = 1'b0;
                end
            end else if (v && !mCur) begin
                mArmed    = 1'b1;
                mLastRise = mCyc;
            end
            mCur = v;
        end
    endtask

    task automatic tone(input int h, input int l, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            drv(1'b1, h);
            drv(1'b0, l);
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        toneIn = 1'b0;
        repeat (3) @(negedge clockIn);
        #1;
        nTests++;
        if ({period, step, inRange, periodValid, locked, noSignal} !== {16'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            nFail++;
            $display("FAIL reset_values: got p=%0d s=%0d ir=%b pv=%b lk=%b ns=%b want p=0 s=0 ir=0 pv=0 lk=0 ns=1",
                     period, step, inRange, periodValid, locked, noSignal);
        end
        @(negedge clockIn);
        resetN = 1'b1;
        modelReset();
        drv(1'b0, 5);
        nTests++;
        if (noSignal !== 1'b1 || periodValid !== 1'b0) begin
            nFail++;
            $display("FAIL idle_after_reset: got ns=%b pv=%b want ns=1 pv=0", noSignal, periodValid);
        end
    endtask

    task automatic test_lock_base();
        tone(28, 28, 3);
        drv(1'b1, 28);
        drv(1'b0, 8);
        nTests++;
        if (locked !== 1'b1 || noSignal !== 1'b0) begin
            nFail++;
            $display("FAIL lock_base: got lk=%b ns=%b want lk=1 ns=0", locked, noSignal);
        end
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            nTests++;
            if (obsQ.size() == 0) begin
                nFail++;
                $display("FAIL lock_base_pulse: got no pulse want p=%0d", e.p);
            end else begin
                o = obsQ.pop_front();
                if (o !== e) begin
                    nFail++;
                    $display("FAIL lock_base_meas: got p=%0d s=%0d ir=%b lk=%b ns=%b want p=%0d s=%0d ir=%b lk=%b ns=%b",
                             o.p, o.s, o.ir, o.lk, o.ns, e.p, e.s, e.ir, e.lk, e.ns);
                end
            end
        end
        nTests++;
        if (obsQ.size() != 0) begin
            nFail++;
            $display("FAIL lock_base_extra: got %0d extra pulses want 0", obsQ.size());
            obsQ.delete();
        end
    endtask

    task automatic test_steps();
        tone(32, 32, 3);
        tone(40, 40, 3);
        for (int k = 0; k < 6; k++) begin
            int s;
            s = int'($urandom_range(0, MAXSTP));
            tone(int'(N) + s, int'(N) + s, int'($urandom_range(2, 3)));
        end
        drv(1'b1, 28);
        drv(1'b0, 8);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            nTests++;
            if (obsQ.size() == 0) begin
                nFail++;
                $display("FAIL steps_pulse: got no pulse want p=%0d", e.p);
            end else begin
                o = obsQ.pop_front();
                if (o !== e) begin
                    nFail++;
                    $display("FAIL steps_meas: got p=%0d s=%0d ir=%b lk=%b ns=%b want p=%0d s=%0d ir=%b lk=%b ns=%b",
                             o.p, o.s, o.ir, o.lk, o.ns, e.p, e.s, e.ir, e.lk, e.ns);
                end
            end
        end
        nTests++;
        if (obsQ.size() != 0) begin
            nFail++;
            $display("FAIL steps_extra: got %0d extra pulses want 0", obsQ.size());
            obsQ.delete();
        end
    endtask

    task automatic test_out_of_range();
        tone(20, 20, 3);
        tone(28, 29, 3);
        for (int k = 0; k < 10; k++) begin
            tone(int'($urandom_range(5, 60)), int'($urandom_range(5, 60)), int'($urandom_range(1, 3)));
        end
        drv(1'b1, 28);
        drv(1'b0, 8);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            nTests++;
            if (obsQ.size() == 0) begin
                nFail++;
                $display("FAIL range_pulse: got no pulse want p=%0d", e.p);
            end else begin
                o = obsQ.pop_front();
                if (o !== e) begin
                    nFail++;
                    $display("FAIL range_meas: got p=%0d s=%0d ir=%b lk=%b ns=%b want p=%0d s=%0d ir=%b lk=%b ns=%b",
                             o.p, o.s, o.ir, o.lk, o.ns, e.p, e.s, e.ir, e.lk, e.ns);
                end
            end
        end
        nTests++;
        if (obsQ.size() != 0) begin
            nFail++;
            $display("FAIL range_extra: got %0d extra pulses want 0", obsQ.size());
            obsQ.delete();
        end
    endtask

    task automatic test_timeout();
        tone(28, 28, 3);
        nsRiseCyc = -1;
        drv(1'b1, 28);
        drv(1'b0, 1100);
        nTests++;
        if (nsRiseCyc - pvCyc != int'(MAXCNT)) begin
            nFail++;
            $display("FAIL timeout_latency: got %0d cycles want %0d", nsRiseCyc - pvCyc, MAXCNT);
        end
        nTests++;
        if ({noSignal, locked, inRange, period} !== {1'b1, 1'b0, 1'b0, 16'd56}) begin
            nFail++;
            $display("FAIL timeout_state: got ns=%b lk=%b ir=%b p=%0d want ns=1 lk=0 ir=0 p=56",
                     noSignal, locked, inRange, period);
        end
        // Resume: first rise only re-arms
        drv(1'b1, 28);
        drv(1'b0, 20);
        nTests++;
        if (noSignal !== 1'b1) begin
            nFail++;
            $display("FAIL rearm_no_pulse: got ns=%b want ns=1", noSignal);
        end
        drv(1'b0, 8);
        tone(28, 28, 2);
        drv(1'b1, 8);
        nTests++;
        if (noSignal !== 1'b0) begin
            nFail++;
            $display("FAIL resume_signal: got ns=%b want ns=0", noSignal);
        end
        drv(1'b0, 8);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            nTests++;
            if (obsQ.size() == 0) begin
                nFail++;
                $display("FAIL timeout_pulse: got no pulse want p=%0d", e.p);
            end else begin
                o = obsQ.pop_front();
                if (o !== e) begin
                    nFail++;
                    $display("FAIL timeout_meas: got p=%0d s=%0d ir=%b lk=%b ns=%b want p=%0d s=%0d ir=%b lk=%b ns=%b",
                             o.p, o.s, o.ir, o.lk, o.ns, e.p, e.s, e.ir, e.lk, e.ns);
                end
            end
        end
        nTests++;
        if (obsQ.size() != 0) begin
            nFail++;
            $display("FAIL timeout_extra: got %0d extra pulses want 0", obsQ.size());
            obsQ.delete();
        end
    endtask

    task automatic test_boundary();
        int h;
        // Previous tone ended low and armed; this rise closes a period
        drv(1'b1, 20);
        drv(1'b0, int'(MAXCNT) - 20);
        drv(1'b1, 10);
        drv(1'b0, 5);
        nTests++;
        if (noSignal !== 1'b0 || period !== 16'd1024) begin
            nFail++;
            $display("FAIL boundary_1024: got ns=%b p=%0d want ns=0 p=1024", noSignal, period);
        end
        h = int'($urandom_range(1, MAXCNT - 1));
        drv(1'b1, h);
        drv(1'b0, int'(MAXCNT) - h);
        drv(1'b1, 10);
        drv(1'b0, 5);
        // One cycle too long: timeout, then rise only re-arms
        h = int'($urandom_range(1, MAXCNT - 1));
        drv(1'b1, h);
        drv(1'b0, int'(MAXCNT) + 1 - h);
        drv(1'b1, 10);
        drv(1'b0, 5);
        nTests++;
        if (noSignal !== 1'b1) begin
            nFail++;
            $display("FAIL boundary_1025: got ns=%b want ns=1", noSignal);
        end
        tone(28, 28, 1);
        drv(1'b1, 8);
        drv(1'b0, 8);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            nTests++;
            if (obsQ.size() == 0) begin
                nFail++;
                $display("FAIL boundary_pulse: got no pulse want p=%0d", e.p);
            end else begin
                o = obsQ.pop_front();
                if (o !== e) begin
                    nFail++;
                    $display("FAIL boundary_meas: got p=%0d s=%0d ir=%b lk=%b ns=%b want p=%0d s=%0d ir=%b lk=%b ns=%b",
                             o.p, o.s, o.ir, o.lk, o.ns, e.p, e.s, e.ir, e.lk, e.ns);
                end
            end
        end
        nTests++;
        if (obsQ.size() != 0) begin
            nFail++;
            $display("FAIL boundary_extra: got %0d extra pulses want 0", obsQ.size());
            obsQ.delete();
        end
    endtask

    task automatic test_reset_mid();
        tone(28, 28, 3);
        drv(1'b1, 28);
        drv(1'b0, 10);
        nTests++;
        if (locked !== 1'b1) begin
            nFail++;
            $display("FAIL mid_reset_pre_lock: got lk=%b want lk=1", locked);
        end
        @(negedge clockIn);
        resetN = 1'b0;
        toneIn = 1'b0;
        #1;
        nTests++;
        if ({period, step, inRange, periodValid, locked, noSignal} !== {16'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            nFail++;
            $display("FAIL mid_reset_values: got p=%0d s=%0d ir=%b pv=%b lk=%b ns=%b want p=0 s=0 ir=0 pv=0 lk=0 ns=1",
                     period, step, inRange, periodValid, locked, noSignal);
        end
        repeat (3) @(negedge clockIn);
        resetN = 1'b1;
        modelReset();
        drv(1'b1, 28);
        drv(1'b0, 28);
        nTests++;
        if (obsQ.size() != 0) begin
            nFail++;
            $display("FAIL mid_reset_first_rise: got %0d pulses want 0", obsQ.size());
        end
        tone(28, 28, 2);
        drv(1'b1, 28);
        drv(1'b0, 8);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            nTests++;
            if (obsQ.size() == 0) begin
                nFail++;
                $display("FAIL mid_reset_pulse: got no pulse want p=%0d", e.p);
            end else begin
                o = obsQ.pop_front();
                if (o !== e) begin
                    nFail++;
                    $display("FAIL mid_reset_meas: got p=%0d s=%0d ir=%b lk=%b ns=%b want p=%0d s=%0d ir=%b lk=%b ns=%b",
                             o.p, o.s, o.ir, o.lk, o.ns, e.p, e.s, e.ir, e.lk, e.ns);
                end
            end
        end
        nTests++;
        if (obsQ.size() != 0) begin
            nFail++;
            $display("FAIL mid_reset_extra: got %0d extra pulses want 0", obsQ.size());
            obsQ.delete();
        end
    endtask

    initial begin
        test_reset();
        test_lock_base();
        test_steps();
        test_out_of_range();
        test_timeout();
        test_boundary();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/tone_period_meter.md
Name: tone_period_meter

Overview:
Receive-side counterpart of the tone divider. Measures the period of an incoming square-wave tone in clockIn cycles and recovers the modulation step the generator applied. The generator produces half-period = N + floor(modulador/10), where N = FrecIn/(2*FrecOut). Sits between a pin-level tone input and the control/display logic; reports period, decoded step, lock status and loss-of-signal.

Parameters:
FrecIn, 25000, clockIn frequency in Hz
FrecOut, 440, base tone frequency in Hz; N = FrecIn/(2*FrecOut) (28 at defaults)
MaxStep, 12, largest legal step (127/10)
MaxCount, 1024, timeout in clockIn cycles without a rising edge
CntW, 16, width of period counter/output; MaxCount < 2^CntW

Ports:
clockIn  input  1  system clock; all logic on posedge
resetN  input  1  asynchronous, active-low reset
toneIn  input  1  asynchronous square-wave tone
period  output CntW  last measured full period in cycles
step  output 4  decoded step = period/2 - N
inRange  output 1  step valid for the last period
periodValid  output 1  one-cycle pulse when period/step/inRange update
locked  output 1  two consecutive equal in-range periods
noSignal  output 1  no rising edge within MaxCount cycles

Behaviour:
- Reset (resetN=0, async): period=0, step=0, inRange=0, periodValid=0, locked=0, noSignal=1, state=IDLE, counter=0, synchronizer flops=0.
- Input path: toneIn -> 2-flop synchronizer -> prev register; rise = sync & ~prev. Fixed 3-cycle input latency is common to all edges, so it does not affect period.
- FSM states: IDLE, MEASURE.
- IDLE: counter held at 0. On rise -> MEASURE, counter=1. No periodValid.
- MEASURE, each cycle without rise: counter+1.
- MEASURE, on rise: period<=counter, step/inRange<=decode(counter), periodValid=1 for exactly that cycle, noSignal<=0, counter<=1.
- MEASURE, counter==MaxCount with no rise: noSignal<=1, locked<=0, inRange<=0, go to IDLE, counter<=0. period/step keep their last values. If rise occurs in the same cycle as counter==MaxCount, the rise wins: normal measurement, no timeout.
- Decode (registered with period, same cycle): half=counter>>1. inRange=1 and step=half-N only if counter is even, half>=N, and half-N<=MaxStep. Otherwise inRange=0, step=0.
- locked: on each periodValid, set to 1 if the new period equals the previous measured period and the new inRange=1. Otherwise cleared. The first measurement after IDLE always leaves locked=0 (previous period invalidated on entry to IDLE).
- Arithmetic: counter saturation is impossible because timeout fires first. The subtraction half-N is evaluated only when half>=N (no wrap).
- Reset mid-measurement aborts the measurement; no periodValid is emitted.

Test Plan:
1. Release resetN, toneIn square wave with half-period 28 cycles (mod=0) -> first periodValid on 2nd rise: period=56, step=0, inRange=1, locked=0. At 3rd rise: locked=1, noSignal=0.
2. Half-period 32 (mod=45, step 4) -> period=64, step=4, inRange=1. Switch to half-period 40 (mod=127) -> first new measurement: period=80, step=12, locked=0. Next measurement: locked=1.
3. Half-period 20 (period 40) -> periodValid with inRange=0, step=0, locked=0. Asymmetric 28/29 high/low (period 57) -> inRange=0.
4. Stop toggling toneIn after a rise -> exactly MaxCount=1024 cycles later noSignal=1, locked=0, inRange=0; period holds 56. Resume toggling -> first rise re-arms with no pulse, second rise gives periodValid and noSignal=0.
5. Rise on exactly the counter==MaxCount cycle (period 1024) -> periodValid with period=1024, inRange=0, noSignal stays 0.
6. Assert resetN mid-period while locked -> all outputs go to reset values immediately. No periodValid until two rises after release.
